// File: rtl/per2axi_bridge.sv
// Peripheral-interconnect to AXI4 single-beat master bridge, one transaction outstanding.
// Optional response timeout with late-response drain is enabled by defining PER2AXI_TIMEOUT_EN.
module per2axi_bridge #(
  parameter int PER_ADDR_WIDTH = 32,
  parameter int PER_ID_WIDTH   = 5,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 6,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        per_slave_req_i,
  input  logic [PER_ADDR_WIDTH-1:0]   per_slave_add_i,
  input  logic                        per_slave_we_ni,
  input  logic [31:0]                 per_slave_wdata_i,
  input  logic [3:0]                  per_slave_be_i,
  input  logic [PER_ID_WIDTH-1:0]     per_slave_id_i,
  output logic                        per_slave_gnt_o,
  output logic                        per_slave_r_valid_o,
  output logic                        per_slave_r_opc_o,
  output logic [31:0]                 per_slave_r_rdata_o,
  output logic [PER_ID_WIDTH-1:0]     per_slave_r_id_o,
  output logic                        axi_master_aw_valid_o,
  input  logic                        axi_master_aw_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_master_aw_addr_o,
  output logic [AXI_ID_WIDTH-1:0]     axi_master_aw_id_o,
  output logic [7:0]                  axi_master_aw_len_o,
  output logic [2:0]                  axi_master_aw_size_o,
  output logic [1:0]                  axi_master_aw_burst_o,
  output logic                        axi_master_aw_lock_o,
  output logic [3:0]                  axi_master_aw_cache_o,
  output logic [2:0]                  axi_master_aw_prot_o,
  output logic [3:0]                  axi_master_aw_qos_o,
  output logic [3:0]                  axi_master_aw_region_o,
  output logic [5:0]                  axi_master_aw_atop_o,
  output logic                        axi_master_ar_valid_o,
  input  logic                        axi_master_ar_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_master_ar_addr_o,
  output logic [AXI_ID_WIDTH-1:0]     axi_master_ar_id_o,
  output logic [7:0]                  axi_master_ar_len_o,
  output logic [2:0]                  axi_master_ar_size_o,
  output logic [1:0]                  axi_master_ar_burst_o,
  output logic                        axi_master_ar_lock_o,
  output logic [3:0]                  axi_master_ar_cache_o,
  output logic [2:0]                  axi_master_ar_prot_o,
  output logic [3:0]                  axi_master_ar_qos_o,
  output logic [3:0]                  axi_master_ar_region_o,
  output logic                        axi_master_w_valid_o,
  input  logic                        axi_master_w_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]   axi_master_w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_master_w_strb_o,
  output logic                        axi_master_w_last_o,
  input  logic                        axi_master_b_valid_i,
  output logic                        axi_master_b_ready_o,
  input  logic [1:0]                  axi_master_b_resp_i,
  input  logic [AXI_ID_WIDTH-1:0]     axi_master_b_id_i,
  input  logic                        axi_master_r_valid_i,
  output logic                        axi_master_r_ready_o,
  input  logic [1:0]                  axi_master_r_resp_i,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_master_r_data_i,
  input  logic                        axi_master_r_last_i,
  input  logic [AXI_ID_WIDTH-1:0]     axi_master_r_id_i,
  output logic                        busy_o
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int NLANES = AXI_DATA_WIDTH / 32;
  localparam int LANE_W = (NLANES > 1) ? $clog2(NLANES) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WR     = 3'd1;
  localparam logic [2:0] B_WAIT = 3'd2;
  localparam logic [2:0] AR     = 3'd3;
  localparam logic [2:0] R_WAIT = 3'd4;
  localparam logic [2:0] RESP   = 3'd5;
`ifdef PER2AXI_TIMEOUT_EN
  localparam logic [2:0] DRAIN  = 3'd6;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
`endif

  logic [2:0]                state_q, state_d;
  logic [PER_ADDR_WIDTH-1:0] add_q, add_d;
  logic                      we_n_q, we_n_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [3:0]                be_q, be_d;
  logic [PER_ID_WIDTH-1:0]   id_q, id_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic                      opc_q, opc_d;
  logic [31:0]               rdata_q, rdata_d;
  logic [LANE_W-1:0]         lane;
  logic [PER_ADDR_WIDTH-1:0] aligned_add;
  logic                      in_drain;
  logic                      unused_inputs;

`ifdef PER2AXI_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timed_out_q, timed_out_d;
  logic             expired;
  assign expired  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign in_drain = (state_q == DRAIN);
`else
  assign in_drain = 1'b0;
`endif

  // Word lane inside the AXI data bus selected by the low address bits above the byte offset
  assign lane        = (NLANES > 1) ? add_q[LANE_W+1:2] : '0;
  assign aligned_add = {add_q[PER_ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    state_d   = state_q;
    add_d     = add_q;
    we_n_d    = we_n_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    id_d      = id_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    opc_d     = opc_q;
    rdata_d   = rdata_q;
`ifdef PER2AXI_TIMEOUT_EN
    timed_out_d = timed_out_q;
    cnt_d       = '0;
    if ((state_q == B_WAIT) || (state_q == R_WAIT)) cnt_d = cnt_q + CNT_W'(1);
`endif
    case (state_q)
      IDLE: begin
        if (per_slave_req_i) begin
          add_d     = per_slave_add_i;
          we_n_d    = per_slave_we_ni;
          wdata_d   = per_slave_wdata_i;
          be_d      = per_slave_be_i;
          id_d      = per_slave_id_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          opc_d     = 1'b0;
          rdata_d   = '0;
          state_d   = per_slave_we_ni ? AR : WR;
        end
      end
      WR: begin
        aw_done_d = aw_done_q | axi_master_aw_ready_i;
        w_done_d  = w_done_q | axi_master_w_ready_i;
        if (aw_done_d && w_done_d) state_d = B_WAIT;
      end
      B_WAIT: begin
        if (axi_master_b_valid_i) begin
          opc_d   = axi_master_b_resp_i[1];
          state_d = RESP;
        end
`ifdef PER2AXI_TIMEOUT_EN
        else if (expired) begin
          opc_d       = 1'b1;
          timed_out_d = 1'b1;
          state_d     = RESP;
        end
`endif
      end
      AR: begin
        if (axi_master_ar_ready_i) state_d = R_WAIT;
      end
      R_WAIT: begin
        if (axi_master_r_valid_i) begin
          opc_d   = axi_master_r_resp_i[1];
          rdata_d = axi_master_r_data_i[32*lane +: 32];
          state_d = RESP;
        end
`ifdef PER2AXI_TIMEOUT_EN
        else if (expired) begin
          opc_d       = 1'b1;
          timed_out_d = 1'b1;
          state_d     = RESP;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
`ifdef PER2AXI_TIMEOUT_EN
        if (timed_out_q) state_d = DRAIN;
`endif
      end
`ifdef PER2AXI_TIMEOUT_EN
      // The late response must still be accepted so the slave does not stall forever
      DRAIN: begin
        if ((we_n_q && axi_master_r_valid_i) || (!we_n_q && axi_master_b_valid_i)) begin
          timed_out_d = 1'b0;
          state_d     = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      add_q     <= '0;
      we_n_q    <= 1'b0;
      wdata_q   <= '0;
      be_q      <= '0;
      id_q      <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      opc_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      add_q     <= add_d;
      we_n_q    <= we_n_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      id_q      <= id_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      opc_q     <= opc_d;
      rdata_q   <= rdata_d;
    end
  end

`ifdef PER2AXI_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      timed_out_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      timed_out_q <= timed_out_d;
    end
  end
`endif

  assign per_slave_gnt_o     = per_slave_req_i & (state_q == IDLE);
  assign per_slave_r_valid_o = (state_q == RESP);
  assign per_slave_r_opc_o   = opc_q;
  assign per_slave_r_rdata_o = rdata_q;
  assign per_slave_r_id_o    = id_q;
  assign busy_o              = (state_q != IDLE);

  assign axi_master_aw_valid_o  = (state_q == WR) & ~aw_done_q;
  assign axi_master_aw_addr_o   = AXI_ADDR_WIDTH'(aligned_add);
  assign axi_master_aw_id_o     = AXI_ID_WIDTH'(id_q);
  assign axi_master_aw_len_o    = 8'd0;
  assign axi_master_aw_size_o   = 3'b010;
  assign axi_master_aw_burst_o  = 2'b01;
  assign axi_master_aw_lock_o   = 1'b0;
  assign axi_master_aw_cache_o  = 4'd0;
  assign axi_master_aw_prot_o   = 3'd0;
  assign axi_master_aw_qos_o    = 4'd0;
  assign axi_master_aw_region_o = 4'd0;
  assign axi_master_aw_atop_o   = 6'd0;

  assign axi_master_ar_valid_o  = (state_q == AR);
  assign axi_master_ar_addr_o   = AXI_ADDR_WIDTH'(aligned_add);
  assign axi_master_ar_id_o     = AXI_ID_WIDTH'(id_q);
  assign axi_master_ar_len_o    = 8'd0;
  assign axi_master_ar_size_o   = 3'b010;
  assign axi_master_ar_burst_o  = 2'b01;
  assign axi_master_ar_lock_o   = 1'b0;
  assign axi_master_ar_cache_o  = 4'd0;
  assign axi_master_ar_prot_o   = 3'd0;
  assign axi_master_ar_qos_o    = 4'd0;
  assign axi_master_ar_region_o = 4'd0;

  assign axi_master_w_valid_o = (state_q == WR) & ~w_done_q;
  assign axi_master_w_data_o  = {NLANES{wdata_q}};
  assign axi_master_w_strb_o  = STRB_W'(be_q) << (4 * lane);
  assign axi_master_w_last_o  = axi_master_w_valid_o;

  assign axi_master_b_ready_o = (state_q == B_WAIT) | (in_drain & ~we_n_q);
  assign axi_master_r_ready_o = (state_q == R_WAIT) | (in_drain & we_n_q);

  assign unused_inputs = ^{axi_master_b_id_i, axi_master_r_id_i, axi_master_r_last_i,
                           axi_master_b_resp_i[0], axi_master_r_resp_i[0], add_q[1:0]};

endmodule
